// File: rtl/axi4_lite_write_slave_responder.sv
// AXI4-Lite write-slave endpoint: holds one AW and one W beat, merges them into a
// single byte-masked register-file write and answers on B. Handshake timing is
// programmable per transfer so upstream masters can be stressed.

// Per-channel holding-slot tracker and ready generator (immediate or delay-driven).
module axi4_lite_wsr_ready_gen #(
  parameter bit          DEFAULT_READY = 1'b1,
  parameter int unsigned DELAY_WIDTH   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic                   i_release,
  input  logic [DELAY_WIDTH-1:0] i_delay,
  output logic                   o_ready,
  output logic                   o_full
);

  logic                   r_ready;
  logic                   r_full;
  logic                   r_wait;
  logic [DELAY_WIDTH-1:0] r_cnt;
  logic                   w_hs;

  assign w_hs    = i_valid && r_ready;
  assign o_ready = r_ready;
  assign o_full  = r_full;

  // Slot occupancy plus ready: drops after a handshake, re-arms on release, counts down otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= DEFAULT_READY;
      r_full  <= 1'b0;
      r_wait  <= 1'b0;
      r_cnt   <= '0;
    end else if (i_release) begin
      r_full  <= 1'b0;
      r_ready <= DEFAULT_READY;
      r_wait  <= 1'b0;
    end else if (w_hs) begin
      r_full  <= 1'b1;
      r_ready <= 1'b0;
      r_wait  <= 1'b0;
    end else if (!DEFAULT_READY && !r_full && !r_ready) begin
      if (!r_wait) begin
        if (i_valid) begin
          if (i_delay == '0) begin
            r_ready <= 1'b1;
          end else begin
            r_wait <= 1'b1;
            r_cnt  <= i_delay;
          end
        end
      end else if (!i_valid) begin
        // Valid withdrawn before the handshake: start over on its next assertion.
        r_wait <= 1'b0;
      end else if (r_cnt == DELAY_WIDTH'(1)) begin
        r_ready <= 1'b1;
        r_wait  <= 1'b0;
      end else begin
        r_cnt <= r_cnt - DELAY_WIDTH'(1);
      end
    end
  end

endmodule

module axi4_lite_write_slave_responder #(
  parameter int unsigned                  ADDRESS_WIDTH = 32,
  parameter int unsigned                  DATA_WIDTH    = 32,
  parameter int unsigned                  DELAY_WIDTH   = 5,
  parameter bit                           DEFAULT_READY = 1'b1,
  parameter logic [ADDRESS_WIDTH-1:0]     MIN_ADDRESS   = 'h01,
  parameter logic [ADDRESS_WIDTH-1:0]     MAX_ADDRESS   = 'hff,
  parameter int unsigned                  MEM_DEPTH     = 64,
  parameter bit                           PROT_CHECK    = 1'b0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [ADDRESS_WIDTH-1:0]      awaddr,
  input  logic [2:0]                    awprot,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH/8-1:0]       wstrb,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  input  logic [DELAY_WIDTH-1:0]        delayForAwready,
  input  logic [DELAY_WIDTH-1:0]        delayForWready,
  input  logic [DELAY_WIDTH-1:0]        delayForBvalid,
  input  logic [$clog2(MEM_DEPTH)-1:0]  dbgIdx,
  output logic [DATA_WIDTH-1:0]         dbgData
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [2:0]               prot;
  } aw_slot_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
  } w_slot_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_BDELAY = 2'd2,
    S_BRESP  = 2'd3
  } state_t;

  aw_slot_t               r_aw;
  w_slot_t                r_w;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_bvalid;
  logic                   w_bvalid_nxt;
  logic [1:0]             r_bresp;
  logic [1:0]             w_bresp_nxt;
  logic [DELAY_WIDTH-1:0] r_bcnt;
  logic [DELAY_WIDTH-1:0] w_bcnt_nxt;
  logic                   w_commit_wr;
  logic                   w_release;
  logic                   w_aw_full;
  logic                   w_w_full;
  logic                   w_aw_hs;
  logic                   w_w_hs;
  logic                   w_decode_err;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_unused_prot;
  logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

  axi4_lite_wsr_ready_gen #(
    .DEFAULT_READY (DEFAULT_READY),
    .DELAY_WIDTH   (DELAY_WIDTH)
  ) u_aw_rdy (
    .clk       (aclk),
    .rst_n     (aresetn),
    .i_valid   (awvalid),
    .i_release (w_release),
    .i_delay   (delayForAwready),
    .o_ready   (awready),
    .o_full    (w_aw_full)
  );

  axi4_lite_wsr_ready_gen #(
    .DEFAULT_READY (DEFAULT_READY),
    .DELAY_WIDTH   (DELAY_WIDTH)
  ) u_w_rdy (
    .clk       (aclk),
    .rst_n     (aresetn),
    .i_valid   (wvalid),
    .i_release (w_release),
    .i_delay   (delayForWready),
    .o_ready   (wready),
    .o_full    (w_w_full)
  );

  assign w_aw_hs       = awvalid && awready;
  assign w_w_hs        = wvalid && wready;
  assign w_idx         = r_aw.addr[ADDR_LSB +: IDX_W];
  assign w_decode_err  = (r_aw.addr < MIN_ADDRESS) || (r_aw.addr > MAX_ADDRESS) ||
                         (PROT_CHECK && r_aw.prot[1]);
  assign w_unused_prot = r_aw.prot[2] ^ r_aw.prot[0];
  assign bvalid        = r_bvalid;
  assign bresp         = r_bresp;
  assign dbgData       = r_mem[dbgIdx];

  // Capture each channel's payload on its own handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw <= '0;
      r_w  <= '0;
    end else begin
      if (w_aw_hs) r_aw <= '{addr: awaddr, prot: awprot};
      if (w_w_hs)  r_w  <= '{data: wdata, strb: wstrb};
    end
  end

  // FSM state and registered B-channel outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
      r_bcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bvalid <= w_bvalid_nxt;
      r_bresp  <= w_bresp_nxt;
      r_bcnt   <= w_bcnt_nxt;
    end
  end

  // Next-state: merge slots, decide response, pace bvalid, free slots on B handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_bvalid_nxt = r_bvalid;
    w_bresp_nxt  = r_bresp;
    w_bcnt_nxt   = r_bcnt;
    w_commit_wr  = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_aw_full || w_aw_hs) && (w_w_full || w_w_hs)) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_bresp_nxt = w_decode_err ? RESP_SLVERR : RESP_OKAY;
        w_commit_wr = !w_decode_err;
        w_bcnt_nxt  = delayForBvalid;
        if (delayForBvalid == '0) begin
          w_state_nxt  = S_BRESP;
          w_bvalid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_BDELAY;
        end
      end
      S_BDELAY: begin
        if (r_bcnt <= DELAY_WIDTH'(1)) begin
          w_state_nxt  = S_BRESP;
          w_bvalid_nxt = 1'b1;
        end else begin
          w_bcnt_nxt = r_bcnt - DELAY_WIDTH'(1);
        end
      end
      S_BRESP: begin
        if (bready) begin
          w_bvalid_nxt = 1'b0;
          w_release    = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Register file: cleared by reset, byte-masked write on a decoded commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit_wr) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (r_w.strb[b]) r_mem[w_idx][8*b +: 8] <= r_w.data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_write_slave_responder.sv
// Bench for the AXI4-Lite write-slave responder: instance 0 uses immediate ready
// with protection checking, instance 1 uses delay-driven ready without it.
module tb_axi4_lite_write_slave_responder;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [1:0][31:0] awaddr;
  logic [1:0][2:0]  awprot;
  logic [1:0]       awvalid, awready;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       wvalid, wready;
  logic [1:0][1:0]  bresp;
  logic [1:0]       bvalid, bready;
  logic [1:0][4:0]  dly_aw, dly_w, dly_b;
  logic [1:0][5:0]  dbg_idx;
  logic [1:0][31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] sb_q0[$];
  logic [1:0] sb_q1[$];

  typedef struct {
    int          u;
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [5:0]  idx;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  axi4_lite_write_slave_responder #(.DEFAULT_READY(1'b1), .PROT_CHECK(1'b1)) u_dut0 (
    .aclk(clk), .aresetn(aresetn),
    .awaddr(awaddr[0]), .awprot(awprot[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
    .delayForAwready(dly_aw[0]), .delayForWready(dly_w[0]), .delayForBvalid(dly_b[0]),
    .dbgIdx(dbg_idx[0]), .dbgData(dbg_data[0])
  );

  axi4_lite_write_slave_responder #(.DEFAULT_READY(1'b0), .PROT_CHECK(1'b0)) u_dut1 (
    .aclk(clk), .aresetn(aresetn),
    .awaddr(awaddr[1]), .awprot(awprot[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
    .delayForAwready(dly_aw[1]), .delayForWready(dly_w[1]), .delayForBvalid(dly_b[1]),
    .dbgIdx(dbg_idx[1]), .dbgData(dbg_data[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=handshake", name);
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? sb_q0.size() : sb_q1.size();
  endfunction

  task automatic push(input int u, input logic [1:0] r);
    if (u == 0) sb_q0.push_back(r);
    else        sb_q1.push_back(r);
  endtask

  // Scoreboard: each B handshake is compared against the oldest expected response.
  always @(negedge clk) begin
    if (aresetn === 1'b1 && bvalid[0] && bready[0]) begin
      if (sb_q0.size() == 0) timeout("sb0_unexpected_bvalid");
      else chk("sb0_bresp", 32'(bresp[0]), 32'(sb_q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (aresetn === 1'b1 && bvalid[1] && bready[1]) begin
      if (sb_q1.size() == 0) timeout("sb1_unexpected_bvalid");
      else chk("sb1_bresp", 32'(bresp[1]), 32'(sb_q1.pop_front()));
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Drop each valid after its handshake; called just after a rising edge.
  task automatic finish_hs(input int u);
    bit aw_hs, w_hs;
    int c = 0;
    while ((awvalid[u] || wvalid[u]) && c < 64) begin
      @(negedge clk);
      aw_hs = awvalid[u] && awready[u];
      w_hs  = wvalid[u] && wready[u];
      @(posedge clk); #1;
      if (aw_hs) awvalid[u] = 1'b0;
      if (w_hs)  wvalid[u]  = 1'b0;
      c++;
    end
    if (awvalid[u] || wvalid[u]) begin
      timeout($sformatf("hs_u%0d", u));
      awvalid[u] = 1'b0;
      wvalid[u]  = 1'b0;
    end
  endtask

  task automatic wait_drain(input int u);
    int c = 0;
    while (qsize(u) != 0 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (qsize(u) != 0) begin
      timeout($sformatf("bresp_u%0d", u));
      if (u == 0) sb_q0.delete();
      else        sb_q1.delete();
    end
  endtask

  task automatic do_write(input int u, input logic [31:0] a, input logic [2:0] p,
                          input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    awaddr[u] = a; awprot[u] = p; wdata[u] = d; wstrb[u] = s;
    awvalid[u] = 1'b1; wvalid[u] = 1'b1;
    push(u, er);
    finish_hs(u);
    wait_drain(u);
  endtask

  task automatic chk_mem(input string name, input int u, input logic [5:0] idx, input logic [31:0] exp);
    dbg_idx[u] = idx;
    #1;
    chk(name, dbg_data[u], exp);
  endtask

  initial begin
    bit aw_hs, w_hs;
    tbl[0]  = '{0, 32'h04,  3'b000, 32'h11223344, 4'b0101, 2'b00, 6'd1,  32'hA522A544};
    tbl[1]  = '{0, 32'h00,  3'b000, 32'hFFFFFFFF, 4'b1111, 2'b10, 6'd0,  32'h00000000};
    tbl[2]  = '{0, 32'h100, 3'b000, 32'hFFFFFFFF, 4'b1111, 2'b10, 6'd0,  32'h00000000};
    tbl[3]  = '{0, 32'h08,  3'b010, 32'hFFFFFFFF, 4'b1111, 2'b10, 6'd2,  32'h00000000};
    tbl[4]  = '{0, 32'h08,  3'b000, 32'hDEADBEEF, 4'b0000, 2'b00, 6'd2,  32'h00000000};
    tbl[5]  = '{0, 32'h0B,  3'b000, 32'hCAFEF00D, 4'b1111, 2'b00, 6'd2,  32'hCAFEF00D};
    tbl[6]  = '{0, 32'hFF,  3'b000, 32'h12345678, 4'b1000, 2'b00, 6'd63, 32'h12000000};
    tbl[7]  = '{0, 32'h01,  3'b101, 32'h0000BEEF, 4'b0011, 2'b00, 6'd0,  32'h0000BEEF};
    tbl[8]  = '{1, 32'h08,  3'b010, 32'h13572468, 4'b1111, 2'b00, 6'd2,  32'h13572468};
    tbl[9]  = '{1, 32'h0C,  3'b000, 32'hAABBCCDD, 4'b0110, 2'b00, 6'd3,  32'h00BBCC00};
    tbl[10] = '{1, 32'h104, 3'b000, 32'h99999999, 4'b1111, 2'b10, 6'd1,  32'h00000000};

    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = '0; wdata = '0; wstrb = '0; wvalid = '0;
    bready = 2'b11; dly_aw = '0; dly_w = '0; dly_b = '0; dbg_idx = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_awready0", 32'(awready[0]), 32'd1);
    chk("rst_wready0",  32'(wready[0]),  32'd1);
    chk("rst_awready1", 32'(awready[1]), 32'd0);
    chk("rst_wready1",  32'(wready[1]),  32'd0);
    chk("rst_bvalid",   32'(bvalid),     32'd0);
    chk("rst_bresp",    32'(bresp),      32'd0);
    chk("rst_mem",      dbg_data[0],     32'd0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Simultaneous AW+W at cycle T: COMMIT at T+1, bvalid and new data at T+2.
    awaddr[0] = 32'h04; awprot[0] = '0; wdata[0] = 32'hA5A5A5A5; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; dbg_idx[0] = 6'd1;
    push(0, 2'b00);
    @(negedge clk);
    chk("t1_awready_T", 32'(awready[0]), 32'd1);
    chk("t1_wready_T",  32'(wready[0]),  32'd1);
    @(posedge clk); #1;
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(negedge clk);
    chk("t1_bvalid_T1",  32'(bvalid[0]),  32'd0);
    chk("t1_awready_T1", 32'(awready[0]), 32'd0);
    @(negedge clk);
    chk("t1_bvalid_T2", 32'(bvalid[0]), 32'd1);
    chk("t1_mem_T2",    dbg_data[0],    32'hA5A5A5A5);
    @(negedge clk);
    chk("t1_bvalid_after", 32'(bvalid[0]),  32'd0);
    chk("t1_awready_after", 32'(awready[0]), 32'd1);
    @(posedge clk); #1;

    // Vector table: strobes, decode errors, protection, unaligned, edge addresses.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].u == 1) begin
        dly_aw[1] = 5'($urandom_range(0, 3));
        dly_w[1]  = 5'($urandom_range(0, 3));
        dly_b[1]  = 5'($urandom_range(0, 2));
      end
      do_write(tbl[i].u, tbl[i].addr, tbl[i].prot, tbl[i].data, tbl[i].strb, tbl[i].resp);
      chk_mem($sformatf("vec%0d_mem", i), tbl[i].u, tbl[i].idx, tbl[i].word);
    end

    // Delay-driven ready: awready 4 cycles after awvalid, wready 1, bvalid 6 after COMMIT.
    dly_aw[1] = 5'd3; dly_w[1] = 5'd0; dly_b[1] = 5'd5;
    awaddr[1] = 32'h10; awprot[1] = '0; wdata[1] = 32'h01020304; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    push(1, 2'b00);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("t4_awready_c%0d", k), 32'(awready[1]), 32'(k == 4));
      chk($sformatf("t4_wready_c%0d", k),  32'(wready[1]),  32'(k == 1));
      chk($sformatf("t4_bvalid_c%0d", k),  32'(bvalid[1]),  32'(k == 11));
      aw_hs = awvalid[1] && awready[1];
      w_hs  = wvalid[1] && wready[1];
      @(posedge clk); #1;
      if (aw_hs) awvalid[1] = 1'b0;
      if (w_hs)  wvalid[1]  = 1'b0;
    end
    wait_drain(1);
    chk_mem("t4_mem", 1, 6'd4, 32'h01020304);

    // W ten cycles ahead of AW, then a second write held off by a stalled B.
    bready[0] = 1'b0;
    wdata[0] = 32'h55AA55AA; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    push(0, 2'b00);
    @(negedge clk);
    chk("t5_w_first_ready", 32'(wready[0]), 32'd1);
    @(posedge clk); #1;
    wvalid[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t5_gap_bvalid_c%0d", k),  32'(bvalid[0]),  32'd0);
      chk($sformatf("t5_gap_wready_c%0d", k),  32'(wready[0]),  32'd0);
      chk($sformatf("t5_gap_awready_c%0d", k), 32'(awready[0]), 32'd1);
      @(posedge clk); #1;
    end
    awaddr[0] = 32'h20; awprot[0] = '0; awvalid[0] = 1'b1;
    @(negedge clk);
    chk("t5_aw_ready", 32'(awready[0]), 32'd1);
    @(posedge clk); #1;
    awvalid[0] = 1'b0;
    @(negedge clk);
    chk("t5_bvalid_commit", 32'(bvalid[0]), 32'd0);
    @(posedge clk); #1;
    awaddr[0] = 32'h24; wdata[0] = 32'h0F0F0F0F; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t5_stall_bvalid_c%0d", k),  32'(bvalid[0]),  32'd1);
      chk($sformatf("t5_stall_bresp_c%0d", k),   32'(bresp[0]),   32'd0);
      chk($sformatf("t5_stall_awready_c%0d", k), 32'(awready[0]), 32'd0);
      chk($sformatf("t5_stall_wready_c%0d", k),  32'(wready[0]),  32'd0);
      @(posedge clk); #1;
    end
    bready[0] = 1'b1;
    push(0, 2'b00);
    finish_hs(0);
    wait_drain(0);
    chk_mem("t5_mem_first",  0, 6'd8, 32'h55AA55AA);
    chk_mem("t5_mem_second", 0, 6'd9, 32'h0F0F0F0F);

    // Reset while the B response is still being delayed.
    dly_aw[1] = 5'd0; dly_w[1] = 5'd0; dly_b[1] = 5'd20;
    awaddr[1] = 32'h30; awprot[1] = '0; wdata[1] = 32'h77777777; wstrb[1] = 4'hF;
    awvalid[1] = 1'b1; wvalid[1] = 1'b1;
    finish_hs(1);
    repeat (3) @(posedge clk);
    #2;
    aresetn = 1'b0;
    @(negedge clk);
    chk("t6_bvalid1",  32'(bvalid[1]),  32'd0);
    chk("t6_awready0", 32'(awready[0]), 32'd1);
    chk("t6_wready0",  32'(wready[0]),  32'd1);
    chk("t6_awready1", 32'(awready[1]), 32'd0);
    chk("t6_wready1",  32'(wready[1]),  32'd0);
    for (int i = 0; i < 64; i++) begin
      dbg_idx[0] = 6'(i);
      dbg_idx[1] = 6'(i);
      #1;
      chk($sformatf("t6_mem0_%0d", i), dbg_data[0], 32'd0);
      chk($sformatf("t6_mem1_%0d", i), dbg_data[1], 32'd0);
    end
    @(negedge clk); #2;
    aresetn = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk($sformatf("t6_no_bvalid_c%0d", k), 32'(bvalid[1]), 32'd0);
    end
    @(posedge clk); #1;
    dly_b[1] = 5'd1;
    do_write(1, 32'h30, 3'b000, 32'h89ABCDEF, 4'hF, 2'b00);
    chk_mem("t6_post_mem1", 1, 6'd12, 32'h89ABCDEF);
    do_write(0, 32'h04, 3'b000, 32'h00C0FFEE, 4'hF, 2'b00);
    chk_mem("t6_post_mem0", 0, 6'd1, 32'h00C0FFEE);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(qsize(0) + qsize(1)), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
